// File: rtl/patient_dispatcher.sv
// patient_dispatcher: pulls records from the patient priority queue, hands each
// one to the lowest-index free on-duty doctor and times the consultation with a
// countdown of SVC_BASE << priority cycles.
// Optional build macro DISPATCH_STATS_EN adds per-priority completion counters
// on pri_cnt; without it pri_cnt is tied to zero.
module patient_dispatcher #(
    parameter int NUM_DOC  = 4,
    parameter int SVC_BASE = 4,
    parameter int WAIT_TO  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 q_empty,
    output logic                 deq_req,
    input  logic [3:0]           deq_data,
    input  logic                 deq_valid,
    input  logic [NUM_DOC-1:0]   doc_en,
    output logic [NUM_DOC-1:0]   doc_busy,
    output logic                 assign_valid,
    output logic [1:0]           assign_doc,
    output logic [3:0]           assign_rec,
    output logic [NUM_DOC-1:0]   doc_done,
    output logic [2*NUM_DOC-1:0] doc_pat_id,
    output logic [7:0]           served_cnt,
    output logic                 err_timeout,
    output logic [31:0]          pri_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, ASSIGN} state_t;

    state_t               state, state_nxt;
    logic [3:0]           wait_cnt, wait_cnt_nxt;
    logic [3:0]           rec, rec_nxt;
    logic                 do_assign, err_set;
    logic [NUM_DOC-1:0]   free, fin;
    logic                 any_free;
    logic [1:0]           free_idx;
    logic [5:0]           svc_load;
    logic [2:0]           n_fin;
    logic [8:0]           served_sum;

    // doc_busy is registered, so a doctor finishing this edge is not free until next cycle
    assign free     = doc_en & ~doc_busy;
    assign deq_req  = (state == REQ);
    assign svc_load = 6'(SVC_BASE) << rec[3:2];

    // lowest-index free doctor
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int k = NUM_DOC - 1; k >= 0; k--) begin
            if (free[k]) begin
                any_free = 1'b1;
                free_idx = 2'(k);
            end
        end
    end

    // next-state logic: request, wait for data (bounded), assign
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        rec_nxt      = rec;
        do_assign    = 1'b0;
        err_set      = 1'b0;
        case (state)
            IDLE: if (!q_empty && any_free) state_nxt = REQ;
            REQ: begin
                state_nxt    = WAIT;
                wait_cnt_nxt = '0;
            end
            WAIT: begin
                if (deq_valid) begin
                    rec_nxt   = deq_data;
                    state_nxt = ASSIGN;
                end else if (wait_cnt == 4'(WAIT_TO - 1)) begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            ASSIGN: begin
                // with nobody free the latched record simply waits here
                if (any_free) begin
                    do_assign = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, wait counter and latched record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            rec      <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            rec      <= rec_nxt;
        end
    end

    // assignment report and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            assign_valid <= 1'b0;
            assign_doc   <= '0;
            assign_rec   <= '0;
            err_timeout  <= 1'b0;
        end else begin
            assign_valid <= do_assign;
            if (do_assign) begin
                assign_doc <= free_idx;
                assign_rec <= rec;
            end
            err_timeout <= err_timeout | err_set;
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [NUM_DOC-1:0][1:0] doc_pri;
`endif

    for (genvar k = 0; k < NUM_DOC; k++) begin : g_doc
        logic       busy_q, done_q;
        logic [5:0] timer_q;
        logic [1:0] id_q;
        logic       hit;

        assign hit         = do_assign && (free_idx == 2'(k));
        assign fin[k]      = busy_q && (timer_q == 6'd1);
        assign doc_busy[k] = busy_q;
        assign doc_done[k] = done_q;
        assign doc_pat_id[2*k +: 2] = id_q;

        // per-doctor consultation countdown; id is kept after completion
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
                timer_q <= '0;
                id_q    <= '0;
            end else begin
                done_q <= fin[k];
                if (hit) begin
                    busy_q  <= 1'b1;
                    timer_q <= svc_load;
                    id_q    <= rec[1:0];
                end else if (busy_q) begin
                    timer_q <= timer_q - 6'd1;
                    if (timer_q == 6'd1) busy_q <= 1'b0;
                end
            end
        end

`ifdef DISPATCH_STATS_EN
        // priority remembered so the completion can be binned later
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)   doc_pri[k] <= '0;
            else if (hit) doc_pri[k] <= rec[3:2];
        end
`endif
    end

    // number of consultations ending on this edge
    always_comb begin
        n_fin = '0;
        for (int k = 0; k < NUM_DOC; k++) n_fin = n_fin + 3'(fin[k]);
    end

    assign served_sum = {1'b0, served_cnt} + 9'(n_fin);

    // saturating served counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  served_cnt <= '0;
        else if (served_sum > 9'd255) served_cnt <= 8'd255;
        else                         served_cnt <= served_sum[7:0];
    end

`ifdef DISPATCH_STATS_EN
    logic [3:0][2:0] p_fin;

    // completions per priority bin this edge
    always_comb begin
        p_fin = '0;
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < NUM_DOC; k++)
                if (fin[k] && doc_pri[k] == 2'(p)) p_fin[p] = p_fin[p] + 3'd1;
    end

    // saturating per-priority counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri_cnt <= '0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                if ({1'b0, pri_cnt[8*p +: 8]} + 9'(p_fin[p]) > 9'd255)
                    pri_cnt[8*p +: 8] <= 8'd255;
                else
                    pri_cnt[8*p +: 8] <= pri_cnt[8*p +: 8] + 8'(p_fin[p]);
            end
        end
    end
`else
    assign pri_cnt = '0;
`endif

endmodule

// File: tb/tb_patient_dispatcher.sv
// Directed bench for patient_dispatcher (default parameters 4/4/8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_patient_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        q_empty;
    logic        deq_req;
    logic [3:0]  deq_data;
    logic        deq_valid;
    logic [3:0]  doc_en;
    logic [3:0]  doc_busy;
    logic        assign_valid;
    logic [1:0]  assign_doc;
    logic [3:0]  assign_rec;
    logic [3:0]  doc_done;
    logic [7:0]  doc_pat_id;
    logic [7:0]  served_cnt;
    logic        err_timeout;
    logic [31:0] pri_cnt;

    int checks = 0;
    int errors = 0;

`ifdef DISPATCH_STATS_EN
    localparam logic [31:0] STATS_MID = 32'h0300_0200;
    localparam logic [31:0] STATS_END = 32'h0300_02FF;
`else
    localparam logic [31:0] STATS_MID = 32'h0;
    localparam logic [31:0] STATS_END = 32'h0;
`endif

    patient_dispatcher #(.NUM_DOC(4), .SVC_BASE(4), .WAIT_TO(8)) dut (
        .clk(clk), .rst_n(rst_n), .q_empty(q_empty), .deq_req(deq_req),
        .deq_data(deq_data), .deq_valid(deq_valid), .doc_en(doc_en),
        .doc_busy(doc_busy), .assign_valid(assign_valid), .assign_doc(assign_doc),
        .assign_rec(assign_rec), .doc_done(doc_done), .doc_pat_id(doc_pat_id),
        .served_cnt(served_cnt), .err_timeout(err_timeout), .pri_cnt(pri_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // poll for a dequeue request within a bounded number of cycles
    task automatic wait_req();
        for (int i = 0; i < 200 && !deq_req; i++) @(negedge clk);
        chk("deq_req_seen", 32'(deq_req), 1);
    endtask

    // act as the queue: answer one request with rec one cycle later
    task automatic serve(input logic [3:0] rec, input int exp_doc);
        q_empty = 1'b0;
        wait_req();
        q_empty = 1'b1;
        @(negedge clk);
        deq_valid = 1'b1;
        deq_data  = rec;
        @(negedge clk);
        deq_valid = 1'b0;
        deq_data  = '0;
        @(negedge clk);
        if (exp_doc >= 0) begin
            chk("assign_valid", 32'(assign_valid), 1);
            chk("assign_doc",   32'(assign_doc), 32'(exp_doc));
            chk("assign_rec",   32'(assign_rec), 32'(rec));
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;
        rst_n = 1'b0; q_empty = 1'b1; deq_data = '0; deq_valid = 1'b0; doc_en = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_deq_req",  32'(deq_req), 0);
        chk("rst_busy",     32'(doc_busy), 0);
        chk("rst_assign",   32'(assign_valid), 0);
        chk("rst_served",   32'(served_cnt), 0);
        chk("rst_err",      32'(err_timeout), 0);
        chk("rst_pat_id",   32'(doc_pat_id), 0);
        chk("rst_pri_cnt",  pri_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single patient: pri 2 id 1 -> doctor 0 for 16 cycles
        doc_en = 4'b1111;
        serve(4'b1001, 0);
        chk("single_busy", 32'(doc_busy), 32'h1);
        n = 0;
        while (doc_busy[0] && n < 100) begin n++; @(negedge clk); end
        chk("single_busy_len", n, 16);
        chk("single_done",     32'(doc_done), 32'h1);
        chk("single_served",   32'(served_cnt), 1);
        chk("single_id",       32'(doc_pat_id[1:0]), 1);
        @(negedge clk);
        chk("single_done_off", 32'(doc_done), 0);

        // reset in the middle of a 32-cycle consultation
        serve(4'b1110, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",   32'(doc_busy), 0);
        chk("midrst_served", 32'(served_cnt), 0);
        chk("midrst_pat_id", 32'(doc_pat_id), 0);
        chk("midrst_req",    32'(deq_req), 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (40) begin @(negedge clk); if (doc_done != 0) n++; end
        chk("midrst_no_done", n, 0);

        // fill all doctors; 0,2,3 end together 16 cycles after the first assign
        serve(4'b1000, 0);
        serve(4'b1001, 1);
        serve(4'b0110, 2);
        serve(4'b0011, 3);
        chk("fill_busy", 32'(doc_busy), 32'hF);
        q_empty = 1'b0;
        seen = 1'b0;
        repeat (4) begin @(negedge clk); seen |= deq_req; end
        chk("fill_no_req",   32'(seen), 0);
        chk("fill_done3",    32'(doc_done), 32'hD);
        chk("fill_served3",  32'(served_cnt), 3);
        chk("fill_busy_rem", 32'(doc_busy), 32'h2);
        @(negedge clk);
        chk("fill_req5", 32'(deq_req), 1);
        serve(4'b0001, 0);
        chk("fill_done_d1", 32'(doc_done), 32'h2);
        repeat (10) @(negedge clk);
        chk("fill_served5", 32'(served_cnt), 5);
        chk("fill_pat_id",  32'(doc_pat_id), 32'hE5);
        chk("fill_idle",    32'(doc_busy), 0);

        // duty mask: only doctor 2; drop doc_en while waiting for data
        pulse_reset();
        doc_en = 4'b0100;
        serve(4'b1100, 2);
        serve(4'b1101, 2);
        serve(4'b1110, 2);
        serve(4'b0111, 2);
        q_empty = 1'b0;
        wait_req();
        q_empty = 1'b1;
        @(negedge clk);
        deq_valid = 1'b1; deq_data = 4'b0110; doc_en = 4'b0000;
        @(negedge clk);
        deq_valid = 1'b0; deq_data = '0;
        seen = 1'b0;
        repeat (5) begin @(negedge clk); seen |= assign_valid; end
        chk("hold_no_assign", 32'(seen), 0);
        chk("hold_idle",      32'(doc_busy), 0);
        doc_en = 4'b0100;
        @(negedge clk);
        chk("hold_assign",     32'(assign_valid), 1);
        chk("hold_assign_doc", 32'(assign_doc), 2);
        chk("hold_assign_rec", 32'(assign_rec), 32'h6);
        repeat (20) @(negedge clk);
        chk("duty_served",  32'(served_cnt), 5);
        chk("duty_pat_id",  32'(doc_pat_id), 32'h20);
        chk("duty_pri_cnt", pri_cnt, STATS_MID);
        chk("duty_err",     32'(err_timeout), 0);

        // timeout: request never answered
        doc_en = 4'b1111;
        q_empty = 1'b0;
        wait_req();
        repeat (8) @(negedge clk);
        chk("to_err_before", 32'(err_timeout), 0);
        @(negedge clk);
        chk("to_err_set", 32'(err_timeout), 1);
        serve(4'b0000, 0);
        chk("to_err_sticky", 32'(err_timeout), 1);

        // saturation of served_cnt (and pri 0 bin when stats are built)
        for (int i = 0; i < 260; i++) serve(4'b0000, -1);
        repeat (10) @(negedge clk);
        chk("sat_served",  32'(served_cnt), 255);
        chk("sat_pri_cnt", pri_cnt, STATS_END);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
